spart_tx_buffered: RTL and testbench

UART transmit engine for the SPART: the transmit side, complementing the receive path. It accepts bytes from the bus interface into a small FIFO and serialises each one onto txd as a standard 8N1 frame: one start bit, 8 data bits LSB first, one stop bit. The bit period comes from the baud divisor that the SPART bus logic loads from br_cfg. It sits beside the receiver inside spart, between the databus write decode and the txd pin.

---
 rtl/spart_pkg.sv | 33 +++
 rtl/spart_fifo.sv | 65 ++++++
 rtl/spart_tx_buffered.sv | 136 +++++++++++++
 tb/tb_spart_tx_buffered.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared SPART definitions: transmit FSM states, frame constants and the
// default baud divisors selected by br_cfg (also used by the receiver).
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    localparam logic [15:0] DIV_CFG_FAST   = 16'd651;
    localparam logic [15:0] DIV_CFG_MID_HI = 16'd1302;
    localparam logic [15:0] DIV_CFG_MID_LO = 16'd2604;
    localparam logic [15:0] DIV_CFG_SLOW   = 16'd5208;

    // br_cfg 2'b11 selects the fastest rate, 2'b00 the slowest.
    function automatic logic [15:0] br_cfg_divisor(input logic [1:0] br_cfg);
        logic [15:0] div;
        case (br_cfg)
            2'b11:   div = DIV_CFG_FAST;
            2'b10:   div = DIV_CFG_MID_HI;
            2'b01:   div = DIV_CFG_MID_LO;
            default: div = DIV_CFG_SLOW;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/spart_fifo.sv
// Synchronous FIFO with first-word fall-through head, so the transmitter can
// pop and load its shift register in the same cycle.
module spart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    // Full is judged on the registered count, so a write while full is lost
    // even if a pop frees a slot in the same cycle.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;
    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/spart_tx_buffered.sv
// SPART transmitter: buffers bytes in a small FIFO and sends each as an 8N1
// frame on txd, with back-to-back frames emitted without an idle gap.
module spart_tx_buffered
    import spart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIV_W-1:0]         divisor,
    input  logic [7:0]               tx_data,
    input  logic                     tx_wr,
    output logic                     tbr,
    output logic                     tx_busy,
    output logic                     txd,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);
    tx_state_t        state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic [DIV_W-1:0] div_eff;
    logic             baud_last;

    spart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign div_eff   = (divisor < DIV_W'(2)) ? DIV_W'(2) : divisor;
    assign baud_last = (baud_q == div_q - 1'b1);
    assign tbr       = !fifo_full;
    assign tx_busy   = (state_q != IDLE) || (fifo_cnt != '0);
    assign txd       = txd_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    div_d   = div_eff;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        div_d   = div_eff;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // txd follows the next state so the line level lines up with state_q.
        case (state_d)
            START:   txd_d = START_BIT;
            DATA:    txd_d = shift_d[0];
            default: txd_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            div_q   <= DIV_W'(2);
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: tb/tb_spart_tx_buffered.sv
// Directed bench for spart_tx_buffered: a line monitor decodes every frame on
// txd and compares it with the scoreboard of bytes the stimulus queued.
module tb_spart_tx_buffered;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [DIV_W-1:0]       divisor;
    logic [7:0]             tx_data;
    logic                   tx_wr;
    logic                   tbr;
    logic                   tx_busy;
    logic                   txd;
    logic [$clog2(DEPTH):0] fifo_cnt;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t exp_q[$];
    int   starts[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   frames_done = 0;
    int   frames_aborted = 0;

    spart_tx_buffered #(
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .divisor  (divisor),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tbr      (tbr),
        .tx_busy  (tx_busy),
        .txd      (txd),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input int d);
        exp_t e;
        e.data = b;
        e.div  = d;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [7:0] b);
        tx_data = b;
        tx_wr   = 1'b1;
        @(posedge clk);
        #1;
        tx_wr   = 1'b0;
    endtask

    task automatic busy_cycles(output int n, input int budget);
        n = 0;
        while (tx_busy === 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Line monitor: one check of the full bit pattern and one of the byte per frame.
    initial begin
        exp_t e;
        int   errs;
        int   bitpos;
        bit   aborted;
        logic expb;
        logic [7:0] obs;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && txd === 1'b0) begin
                starts.push_back(cyc);
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    errs = 0;
                    aborted = 1'b0;
                    obs = '0;
                    for (int k = 0; k < 10 * e.div; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        bitpos = k / e.div;
                        if (bitpos == 0)      expb = 1'b0;
                        else if (bitpos == 9) expb = 1'b1;
                        else                  expb = e.data[bitpos-1];
                        if (txd !== expb) errs++;
                        if ((k % e.div) == (e.div / 2) && bitpos >= 1 && bitpos <= 8)
                            obs[bitpos-1] = txd;
                    end
                    if (aborted) begin
                        frames_aborted++;
                    end else begin
                        check("frame_bit_errors", 32'(errs), 32'd0);
                        check("frame_byte", 32'(obs), 32'(e.data));
                        frames_done++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int f0;

        // Reset hold with a write strobe that must be ignored.
        rst = 1'b0;
        divisor = 16'd4;
        tx_data = 8'h55;
        tx_wr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tbr", 32'(tbr), 32'd1);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b1;
        tx_wr = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(tx_busy), 32'd0);
        check("post_rst_frames", 32'(frames_done), 32'd0);

        // Single byte, divisor 4.
        push(8'hA5, 4);
        wr(8'hA5);
        check("a5_txd_at_write", 32'(txd), 32'd1);
        @(posedge clk);
        #1;
        check("a5_start_latency", 32'(txd), 32'd0);
        check("a5_cnt_popped", 32'(fifo_cnt), 32'd0);
        busy_cycles(n, 200);
        check("a5_busy_len", 32'(n), 32'd40);
        check("a5_frames", 32'(frames_done), 32'd1);

        // Back-to-back frames must be contiguous.
        repeat (3) @(posedge clk);
        #1;
        push(8'hE7, 4);
        push(8'h24, 4);
        wr(8'hE7);
        wr(8'h24);
        busy_cycles(n, 300);
        check("b2b_busy_len", 32'(n), 32'd80);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_frames", 32'(frames_done), 32'd3);
        check("b2b_gap", 32'(starts[starts.size()-1] - starts[starts.size()-2]), 32'd40);

        // Overfill: 01 pops at once, 02..05 fill the FIFO, 06 is dropped.
        f0 = frames_done;
        for (int i = 1; i <= 5; i++) push(8'(i), 4);
        for (int i = 1; i <= 5; i++) wr(8'(i));
        check("full_cnt", 32'(fifo_cnt), 32'd4);
        check("full_tbr", 32'(tbr), 32'd0);
        wr(8'h06);
        check("full_cnt_after_drop", 32'(fifo_cnt), 32'd4);
        busy_cycles(n, 400);
        check("full_busy_len", 32'(n), 32'd196);
        repeat (3) @(posedge clk);
        #1;
        check("full_frames", 32'(frames_done - f0), 32'd5);
        check("full_tbr_after", 32'(tbr), 32'd1);

        // Divisor change during DATA applies only to the next frame.
        push(8'h11, 4);
        push(8'h22, 8);
        wr(8'h11);
        wr(8'h22);
        repeat (6) @(posedge clk);
        #1;
        divisor = 16'd8;
        busy_cycles(n, 400);
        repeat (3) @(posedge clk);
        #1;
        check("divchg_frames", 32'(frames_done - f0), 32'd7);
        check("divchg_first_len", 32'(starts[starts.size()-1] - starts[starts.size()-2]), 32'd40);

        // Reset during data bit 3 at divisor 651 aborts and discards the queue.
        divisor = 16'd651;
        f0 = frames_done;
        push(8'hC3, 651);
        wr(8'hC3);
        wr(8'h5A);
        repeat (651 * 4 + 300) @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(tx_busy), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_cnt", 32'(fifo_cnt), 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b1;
        repeat (1500) @(posedge clk);
        #1;
        check("midrst_aborted", 32'(frames_aborted), 32'd1);
        check("midrst_no_residual", 32'(frames_done - f0), 32'd0);
        check("midrst_idle_txd", 32'(txd), 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
